// File: rtl/mtm_riscv_soc_pkg.sv
// Shared SoC types.
// Ownership tags for the code RAM arbitration path.
package mtm_riscv_soc_pkg;

  typedef enum logic [1:0] {
    CODE_RAM_NONE,
    CODE_RAM_INSTR,
    CODE_RAM_DATA
  } code_ram_owner_t;

endpackage

// File: rtl/code_ram_arbiter_rr.sv
// Two-master round-robin arbiter.
// req[0]/gnt[0] is the INSTR slot, req[1]/gnt[1] the DATA slot.
module rr_arbiter_2
  import mtm_riscv_soc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  code_ram_owner_t last_q;
  code_ram_owner_t last_d;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        // The master that did not win last time goes first.
        if (last_q == CODE_RAM_INSTR) gnt = 2'b10;
        else                          gnt = 2'b01;
      end
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (gnt[0])      last_d = CODE_RAM_INSTR;
    else if (gnt[1]) last_d = CODE_RAM_DATA;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= CODE_RAM_DATA;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/code_ram_arbiter.sv
// Code RAM sharing between fetch and data buses.
// Drives the RAM port and routes the 1-cycle read response.
module code_ram_arbiter
  import mtm_riscv_soc_pkg::*;
#(
  parameter int RAM_AW = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_req,
  input  logic [31:0]       instr_addr,
  output logic              instr_gnt,
  output logic              instr_rvalid,
  output logic [31:0]       instr_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [3:0]        data_be,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [31:0]       data_rdata,
  output logic              ram_req,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  logic [1:0]      gnt;
  code_ram_owner_t owner_q;
  code_ram_owner_t owner_d;

  rr_arbiter_2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({data_req, instr_req}),
    .gnt   (gnt)
  );

  assign instr_gnt = gnt[0];
  assign data_gnt  = gnt[1];
  assign ram_req   = instr_gnt | data_gnt;
  assign ram_wdata = data_wdata;

  always_comb begin
    ram_we   = 1'b0;
    ram_be   = 4'h0;
    ram_addr = '0;
    owner_d  = CODE_RAM_NONE;
    unique case (1'b1)
      instr_gnt: begin
        ram_be   = 4'hF;
        ram_addr = instr_addr[RAM_AW+1:2];
        owner_d  = CODE_RAM_INSTR;
      end
      data_gnt: begin
        ram_we   = data_we;
        ram_be   = data_be;
        ram_addr = data_addr[RAM_AW+1:2];
        owner_d  = CODE_RAM_DATA;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) owner_q <= CODE_RAM_NONE;
    else        owner_q <= owner_d;
  end

  assign instr_rvalid = (owner_q == CODE_RAM_INSTR);
  assign data_rvalid  = (owner_q == CODE_RAM_DATA);
  assign instr_rdata  = ram_rdata;
  assign data_rdata   = ram_rdata;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{instr_addr[31:RAM_AW+2],
                              instr_addr[1:0],
                              data_addr[31:RAM_AW+2],
                              data_addr[1:0]};

endmodule

// File: tb/tb_code_ram_arbiter.sv
// Directed bench for code_ram_arbiter.
// Inputs change after negedge; outputs sampled away from posedge.
module tb_code_ram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        ram_req;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  code_ram_arbiter #(.RAM_AW(14)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_req    (instr_req),
    .instr_addr   (instr_addr),
    .instr_gnt    (instr_gnt),
    .instr_rvalid (instr_rvalid),
    .instr_rdata  (instr_rdata),
    .data_req     (data_req),
    .data_we      (data_we),
    .data_be      (data_be),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_gnt     (data_gnt),
    .data_rvalid  (data_rvalid),
    .data_rdata   (data_rdata),
    .ram_req      (ram_req),
    .ram_we       (ram_we),
    .ram_be       (ram_be),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    instr_req  = 1'b0;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_be    = 4'h0;
    data_wdata = 32'h0;
  endtask

  initial begin
    rst_n      = 1'b0;
    instr_addr = 32'h0;
    data_addr  = 32'h0;
    ram_rdata  = 32'h0;
    idle();

    #12;
    chk("rst_igt", {31'b0, instr_gnt}, 32'd0);
    chk("rst_dgt", {31'b0, data_gnt}, 32'd0);
    chk("rst_rreq", {31'b0, ram_req}, 32'd0);
    chk("rst_be", {28'b0, ram_be}, 32'd0);
    chk("rst_irv", {31'b0, instr_rvalid}, 32'd0);
    chk("rst_drv", {31'b0, data_rvalid}, 32'd0);

    // First fetch right at reset release.
    @(negedge clk);
    rst_n      = 1'b1;
    instr_req  = 1'b1;
    instr_addr = 32'h0000_0104;
    #1;
    chk("f_gnt", {31'b0, instr_gnt}, 32'd1);
    chk("f_rreq", {31'b0, ram_req}, 32'd1);
    chk("f_addr", {18'b0, ram_addr}, 32'h041);
    chk("f_we", {31'b0, ram_we}, 32'd0);
    chk("f_be", {28'b0, ram_be}, 32'hF);
    @(posedge clk);
    #1;
    idle();
    ram_rdata = 32'h1234_5678;
    #1;
    chk("f_irv", {31'b0, instr_rvalid}, 32'd1);
    chk("f_idat", instr_rdata, 32'h1234_5678);
    chk("f_drv", {31'b0, data_rvalid}, 32'd0);

    // Data write, instr idle.
    @(negedge clk);
    data_req   = 1'b1;
    data_we    = 1'b1;
    data_be    = 4'b0011;
    data_addr  = 32'h0000_0010;
    data_wdata = 32'hDEAD_BEEF;
    #1;
    chk("w_gnt", {31'b0, data_gnt}, 32'd1);
    chk("w_igt", {31'b0, instr_gnt}, 32'd0);
    chk("w_we", {31'b0, ram_we}, 32'd1);
    chk("w_be", {28'b0, ram_be}, 32'h3);
    chk("w_addr", {18'b0, ram_addr}, 32'h004);
    chk("w_wdat", ram_wdata, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    idle();
    #1;
    chk("w_drv", {31'b0, data_rvalid}, 32'd1);
    chk("w_irv", {31'b0, instr_rvalid}, 32'd0);

    // Both masters requesting: alternate starting with INSTR.
    instr_addr = 32'h0000_0200;
    data_addr  = 32'h0000_0300;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      instr_req = 1'b1;
      data_req  = 1'b1;
      data_we   = 1'b0;
      data_be   = 4'hF;
      #1;
      chk($sformatf("rr_igt%0d", i), {31'b0, instr_gnt},
          (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr_dgt%0d", i), {31'b0, data_gnt},
          (i % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("rr_addr%0d", i), {18'b0, ram_addr},
          (i % 2 == 0) ? 32'h080 : 32'h0C0);
      @(posedge clk);
      #1;
      chk($sformatf("rr_irv%0d", i), {31'b0, instr_rvalid},
          (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr_drv%0d", i), {31'b0, data_rvalid},
          (i % 2 == 0) ? 32'd0 : 32'd1);
    end
    idle();

    // Data alone, back to back.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data_req  = 1'b1;
      data_we   = 1'b0;
      data_be   = 4'hF;
      data_addr = 32'h0000_0020 + 32'(4 * i);
      #1;
      chk($sformatf("d3_gnt%0d", i), {31'b0, data_gnt}, 32'd1);
      chk($sformatf("d3_addr%0d", i), {18'b0, ram_addr},
          32'h008 + 32'(i));
      @(posedge clk);
      #1;
      chk($sformatf("d3_drv%0d", i), {31'b0, data_rvalid}, 32'd1);
      chk($sformatf("d3_irv%0d", i), {31'b0, instr_rvalid}, 32'd0);
    end
    @(negedge clk);
    idle();
    @(posedge clk);
    #1;
    chk("d3_drv_end", {31'b0, data_rvalid}, 32'd0);

    // Normal fetch so last_grant is INSTR before the reset test.
    @(negedge clk);
    instr_req  = 1'b1;
    instr_addr = 32'h0000_0040;
    #1;
    chk("p_igt", {31'b0, instr_gnt}, 32'd1);
    @(posedge clk);
    #1;
    chk("p_irv", {31'b0, instr_rvalid}, 32'd1);

    // Fetch granted, reset hits before the response edge.
    @(negedge clk);
    instr_req = 1'b1;
    #1;
    chk("r_igt", {31'b0, instr_gnt}, 32'd1);
    #1;
    rst_n = 1'b0;
    idle();
    @(posedge clk);
    #1;
    chk("r_irv", {31'b0, instr_rvalid}, 32'd0);
    chk("r_drv", {31'b0, data_rvalid}, 32'd0);

    // First tie after reset must go to INSTR.
    @(negedge clk);
    rst_n     = 1'b1;
    instr_req = 1'b1;
    data_req  = 1'b1;
    #1;
    chk("pr_igt", {31'b0, instr_gnt}, 32'd1);
    chk("pr_dgt", {31'b0, data_gnt}, 32'd0);
    @(posedge clk);
    #1;
    chk("pr_irv", {31'b0, instr_rvalid}, 32'd1);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/code_ram_arbiter.md
# code_ram_arbiter

Shares the single-port code RAM between the core's instruction-fetch bus and its data bus. It grants at most one requester per cycle, using round-robin on conflicts. It drives the RAM port and routes the one-cycle-latency read response back to the master that issued the access. It sits between the instruction/data bus decoders and the code RAM macro, in the slot the instruction-bus slave select feeds.

## Interface

Parameters:
- RAM_AW, 14: code RAM word-address width (64 KiB). Byte address bits [RAM_AW+1:2] index the RAM.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- instr_req  in  1  fetch request (already decoded to code RAM)
- instr_addr  in  32  fetch byte address
- instr_gnt  out  1  fetch accepted this cycle
- instr_rvalid  out  1  fetch data valid on instr_rdata
- instr_rdata  out  32  fetch read data
- data_req  in  1  data request (already decoded to code RAM)
- data_we  in  1  1 = write
- data_be  in  4  byte enables
- data_addr  in  32  data byte address
- data_wdata  in  32  write data
- data_gnt  out  1  data access accepted this cycle
- data_rvalid  out  1  response valid, for both reads and writes
- data_rdata  out  32  read data (don't-care for writes)
- ram_req  out  1  RAM access strobe
- ram_we  out  1  RAM write
- ram_be  out  4  RAM byte enables
- ram_addr  out  RAM_AW  RAM word address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid the cycle after ram_req

## Operation

- Handshake per master: req is held until gnt. Address and data are sampled in the gnt cycle. Exactly one rvalid follows each gnt.
- Arbitration is combinational from req and the last_grant register:
  - Only one master requesting: that master is granted.
  - Both requesting: the master not in last_grant is granted.
  - last_grant updates on every grant.
- The RAM is fully pipelined, so a grant is possible every cycle, including back-to-back grants to the same master.
- RAM port:
  - ram_req = instr_gnt | data_gnt.
  - Mux selects the granted master's addr[RAM_AW+1:2].
  - An instr grant forces ram_we = 0 and ram_be = 4'hF.
  - With no grant, ram_we = 0 and ram_be = 0.
- Response routing:
  - resp_owner register loads NONE, INSTR or DATA on every clock edge, according to the current grant.
  - instr_rvalid = (resp_owner == INSTR).
  - data_rvalid = (resp_owner == DATA).
- ram_rdata feeds instr_rdata and data_rdata directly (unregistered).
- No misaligned-access checks. Address bits [1:0] are ignored.

## Timing

- Reset values:
  - resp_owner = NONE, so both rvalid outputs are 0.
  - last_grant = DATA, so INSTR wins the first tie.
  - Combinational outputs follow their inputs; with no req, every gnt and ram_req is 0.
- Grant latency: 0 cycles (combinational). Response latency: exactly 1 cycle after gnt.
- Both masters requesting on consecutive cycles alternate INSTR/DATA/INSTR...; each waits at most 1 cycle.
- A req that drops without gnt is legal and has no effect on state.
- Reset asserted mid-transaction: the pending response is dropped, so no rvalid follows. After release, arbitration restarts from the reset state.
- A write's rvalid arrives the cycle after gnt, the same as a read.

## Structure

- mtm_riscv_soc_pkg: add typedef enum logic [1:0] code_ram_owner_t {CODE_RAM_NONE, CODE_RAM_INSTR, CODE_RAM_DATA}. Used for both resp_owner and last_grant.
- One sub-module, rr_arbiter_2:
  - Inputs: clk, rst_n, req[1:0].
  - Output: one-hot gnt[1:0].
  - Holds the last_grant flop and is reusable for other two-master slaves.
- The top level holds the RAM-port mux and the resp_owner flop.

## Test plan

- Reset release with instr_req=1 at addr 0x0000_0104 → same cycle: instr_gnt=1, ram_addr=0x041, ram_we=0, ram_be=4'hF. Next cycle: instr_rvalid=1 and instr_rdata equals ram_rdata; data_rvalid=0.
- instr_req and data_req both held high for 4 cycles → grants INSTR, DATA, INSTR, DATA. Each rvalid goes to the matching master one cycle later.
- Data write: addr 0x0000_0010, be 4'b0011, wdata 0xDEAD_BEEF, instr idle → data_gnt=1, ram_we=1, ram_be=4'b0011, ram_addr=0x004, ram_wdata=0xDEAD_BEEF. data_rvalid=1 the next cycle.
- data_req alone for 3 consecutive cycles → data_gnt=1 on all 3 and data_rvalid=1 on the 3 following cycles; instr_rvalid stays 0 throughout.
- instr granted in cycle N, rst_n asserted in cycle N+1 before the edge → instr_rvalid stays 0, last_grant returns to DATA. The first post-reset tie is granted to INSTR.
